// File: rtl/neokeon_round_iter_pkg.sv
// Neokeon-128 shared definitions: FSM states, round constants, word helpers
// and the Theta/Gamma/rotate primitives used by the round datapath.
package neokeon_round_iter_pkg;

  localparam int unsigned ROUNDS_DEF  = 16;
  localparam logic [7:0]  RC_INIT_DEF = 8'h80;
  localparam logic [7:0]  RC_POLY     = 8'h1b;

  // Pi1 rotates left by these amounts; Pi2 rotates right by the same amounts
  localparam int unsigned PI_R1 = 1;
  localparam int unsigned PI_R2 = 5;
  localparam int unsigned PI_R3 = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } fsm_e;

  // a0 occupies [127:96], a3 occupies [31:0]
  typedef struct packed {
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] a3;
  } blk_t;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] rc);
    return {rc[6:0], 1'b0} ^ (rc[7] ? RC_POLY : 8'h00);
  endfunction

  // Diffusion step: mixes a0/a2 into a1/a3, adds the key, then mixes back
  function automatic blk_t theta_f(input blk_t s, input blk_t k);
    blk_t        r;
    logic [31:0] t;
    r  = s;
    t  = r.a0 ^ r.a2;
    t  = t ^ rotl32(t, 8) ^ rotl32(t, 24);
    r.a1 = r.a1 ^ t;
    r.a3 = r.a3 ^ t;
    r.a0 = r.a0 ^ k.a0;
    r.a1 = r.a1 ^ k.a1;
    r.a2 = r.a2 ^ k.a2;
    r.a3 = r.a3 ^ k.a3;
    t  = r.a1 ^ r.a3;
    t  = t ^ rotl32(t, 8) ^ rotl32(t, 24);
    r.a0 = r.a0 ^ t;
    r.a2 = r.a2 ^ t;
    return r;
  endfunction

  // Non-linear step, bitsliced across the four words
  function automatic blk_t gamma_f(input blk_t s);
    logic [31:0] a0, a1, a2, a3, tmp;
    a0  = s.a0;
    a1  = s.a1;
    a2  = s.a2;
    a3  = s.a3;
    a1  = a1 ^ (~a3 & ~a2);
    a0  = a0 ^ (a2 & a1);
    tmp = a0;
    a0  = a3;
    a3  = tmp;
    a2  = a2 ^ a0 ^ a1 ^ a3;
    a1  = a1 ^ (~a3 & ~a2);
    a0  = a0 ^ (a2 & a1);
    return '{a0: a0, a1: a1, a2: a2, a3: a3};
  endfunction

endpackage

// File: rtl/neokeon_round_iter_round_comb.sv
// Combinational Neokeon round: RC add -> Theta -> Pi1 -> Gamma -> Pi2.
// theta_out exposes the RC-add + Theta result alone for the final output step.
module neokeon_round_comb
  import neokeon_round_iter_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic [7:0]   rc,
  output logic [127:0] round_out,
  output logic [127:0] theta_out
);

  blk_t rc_added;
  blk_t theta_s;
  blk_t pi1_s;
  blk_t gamma_s;
  blk_t pi2_s;

  // Full round datapath; the final step reuses the Theta stage output
  always_comb begin
    rc_added       = blk_t'(state);
    rc_added.a0    = rc_added.a0 ^ {24'h000000, rc};
    theta_s        = theta_f(rc_added, blk_t'(key));
    pi1_s.a0       = theta_s.a0;
    pi1_s.a1       = rotl32(theta_s.a1, PI_R1);
    pi1_s.a2       = rotl32(theta_s.a2, PI_R2);
    pi1_s.a3       = rotl32(theta_s.a3, PI_R3);
    gamma_s        = gamma_f(pi1_s);
    pi2_s.a0       = gamma_s.a0;
    pi2_s.a1       = rotr32(gamma_s.a1, PI_R1);
    pi2_s.a2       = rotr32(gamma_s.a2, PI_R2);
    pi2_s.a3       = rotr32(gamma_s.a3, PI_R3);
    round_out      = pi2_s;
    theta_out      = theta_s;
  end

endmodule

// File: rtl/neokeon_round_iter.sv
// Iterative Neokeon-128 encryption engine, one round per clock, with a
// start/busy request side and a valid/ack result handshake.
module neokeon_round_iter
  import neokeon_round_iter_pkg::*;
#(
  parameter int unsigned ROUNDS  = ROUNDS_DEF,
  parameter logic [7:0]  RC_INIT = RC_INIT_DEF
) (
  input  logic         inClk,
  input  logic         inRst,
  input  logic         inStart,
  input  logic [127:0] inData,
  input  logic [127:0] inKey,
  output logic         outBusy,
  output logic         outValid,
  input  logic         inAck,
  output logic [127:0] outData
);

  localparam int unsigned        CNT_W    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ROUNDS - 1);

  fsm_e             fsm_q,   fsm_d;
  logic [127:0]     state_q, state_d;
  logic [127:0]     key_q,   key_d;
  logic [7:0]       rc_q,    rc_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [127:0]     data_q,  data_d;
  logic             busy_q,  busy_d;
  logic             valid_q, valid_d;

  logic [127:0]     round_out;
  logic [127:0]     theta_out;

  neokeon_round_comb u_round (
    .state     (state_q),
    .key       (key_q),
    .rc        (rc_q),
    .round_out (round_out),
    .theta_out (theta_out)
  );

  // Next-state logic; busy/valid are derived from the next FSM state so the
  // registered outputs line up with the state they describe
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    rc_d    = rc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (fsm_q)
      ST_IDLE: begin
        if (inStart) begin
          fsm_d   = ST_ROUND;
          state_d = inData;
          key_d   = inKey;
          rc_d    = RC_INIT;
          cnt_d   = '0;
        end
      end
      ST_ROUND: begin
        state_d = round_out;
        rc_d    = xtime(rc_q);
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          fsm_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        data_d = theta_out;
        fsm_d  = ST_DONE;
      end
      ST_DONE: begin
        if (inAck) begin
          fsm_d = ST_IDLE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
    busy_d  = (fsm_d != ST_IDLE);
    valid_d = (fsm_d == ST_DONE);
  end

  // State registers with synchronous reset taking priority over everything
  always_ff @(posedge inClk) begin
    if (inRst) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      key_q   <= '0;
      rc_q    <= RC_INIT;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      rc_q    <= rc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign outBusy  = busy_q;
  assign outValid = valid_q;
  assign outData  = data_q;

endmodule
